// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP stream unpacker: FSM states, header field
// offsets, error codes and output pixel format encodings.
package bmp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHdr,
        StSkip,
        StPix,
        StPad,
        StDone,
        StErr
    } bmp_state_e;

    // Byte offsets of the little-endian header fields
    localparam int unsigned SIG_OFS  = 0;
    localparam int unsigned OFFS_OFS = 10;
    localparam int unsigned WID_OFS  = 18;
    localparam int unsigned HGT_OFS  = 22;
    localparam int unsigned BPP_OFS  = 28;
    // Last header byte; all checks are made when it arrives
    localparam int unsigned HDR_LAST = BPP_OFS + 1;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SIG  = 2'd1;
    localparam logic [1:0] ERR_BPP  = 2'd2;
    localparam logic [1:0] ERR_DIM  = 2'd3;

    localparam int unsigned FMT_RGB565 = 0;
    localparam int unsigned FMT_RGB888 = 1;

endpackage

// File: rtl/bmp_pix_pack.sv
// Collects B,G,R(,A) byte lanes of one pixel and emits the converted pixel
// one cycle after its last byte.
module bmp_pix_pack
    import bmp_pkg::*;
#(
    parameter int unsigned OUT_FMT = FMT_RGB565,
    parameter int unsigned OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    input  logic             bpp32,
    output logic             pix_last,
    output logic             pix_en,
    output logic [OUT_W-1:0] pix_data
);

    logic [1:0]       lane_q;
    logic [7:0]       b_q, g_q, r_q;
    logic [7:0]       r_cur;
    logic [OUT_W-1:0] conv;

    // Last lane of the pixel; for 24 bpp R is taken straight from the bus
    always_comb begin
        r_cur    = bpp32 ? r_q : byte_data;
        pix_last = byte_en && (lane_q == (bpp32 ? 2'd3 : 2'd2));
    end

    if (OUT_FMT == FMT_RGB565) begin : g_rgb565
        logic unused_lsbs;
        assign conv        = {r_cur[7:3], g_q[7:2], b_q[7:3]};
        assign unused_lsbs = ^{r_cur[2:0], g_q[1:0], b_q[2:0]};
    end else begin : g_rgb888
        assign conv = {r_cur, g_q, b_q};
    end

    // Lane capture and registered pixel strobe; the alpha lane is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q   <= 2'd0;
            b_q      <= 8'd0;
            g_q      <= 8'd0;
            r_q      <= 8'd0;
            pix_en   <= 1'b0;
            pix_data <= '0;
        end else begin
            pix_en <= 1'b0;
            if (clear) begin
                lane_q <= 2'd0;
            end else if (byte_en) begin
                case (lane_q)
                    2'd0:    b_q <= byte_data;
                    2'd1:    g_q <= byte_data;
                    2'd2:    r_q <= byte_data;
                    default: ;
                endcase
                if (pix_last) begin
                    lane_q   <= 2'd0;
                    pix_en   <= 1'b1;
                    pix_data <= conv;
                end else begin
                    lane_q <= lane_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bmp_stream_unpacker.sv
// BMP byte-stream parser: validates the header, skips to the pixel array,
// strips row padding and emits one converted pixel strobe per pixel.
// Optional header readback ports are enabled by defining BMP_HDR_OUT_EN.
module bmp_stream_unpacker
    import bmp_pkg::*;
#(
    parameter int unsigned OUT_FMT    = FMT_RGB565,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned MAX_WIDTH  = 1024,
    parameter int unsigned MAX_HEIGHT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      expect_width,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             write_req,
    input  logic             write_req_ack,
    output logic             pix_en,
    output logic [OUT_W-1:0] pix_data,
    output logic             busy,
    output logic             done,
    output logic             err,
`ifdef BMP_HDR_OUT_EN
    output logic [15:0]      hdr_width,
    output logic [15:0]      hdr_height,
    output logic [5:0]       hdr_bpp,
    output logic             hdr_top_down,
`endif
    output logic [1:0]       err_code
);

    if (!((OUT_FMT == FMT_RGB565 && OUT_W == 16) ||
          (OUT_FMT == FMT_RGB888 && OUT_W == 24))) begin : g_bad_cfg
        $error("bmp_stream_unpacker: OUT_W does not match OUT_FMT");
    end

    bmp_state_e  state_q;
    logic [31:0] byte_cnt_q;
    logic [7:0]  sig0_q;
    logic        sig_ok_q;
    logic [31:0] off_q, width_q, height_q;
    logic [7:0]  bpp_lo_q;
    logic        bpp32_q;
    logic [1:0]  pad_q, pad_cnt_q;
    logic [15:0] col_q, row_q, rows_q;

    logic        launch, pix_byte_en, pix_last;
    logic [15:0] bpp_full;
    logic [31:0] hgt_abs;
    logic        bpp_ok, width_ok, hgt_ok;
    logic [1:0]  hdr_err;
    logic [1:0]  lane_off, lane_wid, lane_hgt;

    // Header decode and validation, evaluated against the byte on the bus
    always_comb begin
        launch      = start && (state_q == StIdle || state_q == StErr);
        pix_byte_en = byte_valid && (state_q == StPix);
        lane_off    = 2'(byte_cnt_q - 32'(OFFS_OFS));
        lane_wid    = 2'(byte_cnt_q - 32'(WID_OFS));
        lane_hgt    = 2'(byte_cnt_q - 32'(HGT_OFS));
        bpp_full    = {byte_data, bpp_lo_q};
        hgt_abs     = height_q[31] ? (32'd0 - height_q) : height_q;
        bpp_ok      = (bpp_full == 16'd24) || (bpp_full == 16'd32);
        width_ok    = (width_q != 32'd0) && (width_q <= 32'(MAX_WIDTH)) &&
                      ((expect_width == 16'd0) || (width_q == {16'd0, expect_width}));
        hgt_ok      = (hgt_abs != 32'd0) && (hgt_abs <= 32'(MAX_HEIGHT));
        if (!sig_ok_q)                 hdr_err = ERR_SIG;
        else if (!bpp_ok)              hdr_err = ERR_BPP;
        else if (!width_ok || !hgt_ok) hdr_err = ERR_DIM;
        else                           hdr_err = ERR_NONE;
    end

    // Frame sequencing FSM with registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 32'd0;
            sig0_q     <= 8'd0;
            sig_ok_q   <= 1'b0;
            off_q      <= 32'd0;
            width_q    <= 32'd0;
            height_q   <= 32'd0;
            bpp_lo_q   <= 8'd0;
            bpp32_q    <= 1'b0;
            pad_q      <= 2'd0;
            pad_cnt_q  <= 2'd0;
            col_q      <= 16'd0;
            row_q      <= 16'd0;
            rows_q     <= 16'd0;
            write_req  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
`ifdef BMP_HDR_OUT_EN
            hdr_width    <= 16'd0;
            hdr_height   <= 16'd0;
            hdr_bpp      <= 6'd0;
            hdr_top_down <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (launch) begin
                // A start in ERR restarts directly, clearing the sticky error
                state_q    <= StReq;
                write_req  <= 1'b1;
                busy       <= 1'b1;
                err        <= 1'b0;
                err_code   <= ERR_NONE;
                byte_cnt_q <= 32'd0;
                sig_ok_q   <= 1'b0;
                col_q      <= 16'd0;
                row_q      <= 16'd0;
                pad_cnt_q  <= 2'd0;
`ifdef BMP_HDR_OUT_EN
                hdr_width    <= 16'd0;
                hdr_height   <= 16'd0;
                hdr_bpp      <= 6'd0;
                hdr_top_down <= 1'b0;
`endif
            end else begin
                case (state_q)
                    StReq: begin
                        if (write_req_ack) begin
                            write_req <= 1'b0;
                            state_q   <= StHdr;
                        end
                    end
                    StHdr: begin
                        if (byte_valid) begin
                            byte_cnt_q <= byte_cnt_q + 32'd1;
                            if (byte_cnt_q == 32'(SIG_OFS))
                                sig0_q <= byte_data;
                            if (byte_cnt_q == 32'(SIG_OFS + 1))
                                sig_ok_q <= (sig0_q == 8'h42) && (byte_data == 8'h4D);
                            if (byte_cnt_q >= 32'(OFFS_OFS) && byte_cnt_q < 32'(OFFS_OFS + 4))
                                off_q[{lane_off, 3'b000} +: 8] <= byte_data;
                            if (byte_cnt_q >= 32'(WID_OFS) && byte_cnt_q < 32'(WID_OFS + 4))
                                width_q[{lane_wid, 3'b000} +: 8] <= byte_data;
                            if (byte_cnt_q >= 32'(HGT_OFS) && byte_cnt_q < 32'(HGT_OFS + 4))
                                height_q[{lane_hgt, 3'b000} +: 8] <= byte_data;
                            if (byte_cnt_q == 32'(BPP_OFS))
                                bpp_lo_q <= byte_data;
                            if (byte_cnt_q == 32'(HDR_LAST)) begin
`ifdef BMP_HDR_OUT_EN
                                hdr_width    <= width_q[15:0];
                                hdr_height   <= hgt_abs[15:0];
                                hdr_bpp      <= bpp_full[5:0];
                                hdr_top_down <= height_q[31];
`endif
                                if (hdr_err != ERR_NONE) begin
                                    err      <= 1'b1;
                                    err_code <= hdr_err;
                                    busy     <= 1'b0;
                                    state_q  <= StErr;
                                end else begin
                                    bpp32_q <= (bpp_full == 16'd32);
                                    // 24 bpp row length 3*w needs w mod 4 pad bytes
                                    pad_q   <= (bpp_full == 16'd32) ? 2'd0 : width_q[1:0];
                                    rows_q  <= hgt_abs[15:0];
                                    state_q <= (off_q <= 32'(HDR_LAST) + 32'd1) ? StPix
                                                                                : StSkip;
                                end
                            end
                        end
                    end
                    StSkip: begin
                        if (byte_valid) begin
                            byte_cnt_q <= byte_cnt_q + 32'd1;
                            if (byte_cnt_q == off_q - 32'd1) state_q <= StPix;
                        end
                    end
                    StPix: begin
                        if (pix_last) begin
                            if (col_q == width_q[15:0] - 16'd1) begin
                                col_q <= 16'd0;
                                if (row_q == rows_q - 16'd1) begin
                                    // Trailing pad of the last row is left to be dropped
                                    state_q <= StDone;
                                    done    <= 1'b1;
                                    busy    <= 1'b0;
                                end else begin
                                    row_q <= row_q + 16'd1;
                                    if (pad_q != 2'd0) begin
                                        pad_cnt_q <= 2'd0;
                                        state_q   <= StPad;
                                    end
                                end
                            end else begin
                                col_q <= col_q + 16'd1;
                            end
                        end
                    end
                    StPad: begin
                        if (byte_valid) begin
                            pad_cnt_q <= pad_cnt_q + 2'd1;
                            if (pad_cnt_q == pad_q - 2'd1) state_q <= StPix;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    StIdle:  ;
                    StErr:   ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    bmp_pix_pack #(
        .OUT_FMT (OUT_FMT),
        .OUT_W   (OUT_W)
    ) u_pix_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (launch),
        .byte_en   (pix_byte_en),
        .byte_data (byte_data),
        .bpp32     (bpp32_q),
        .pix_last  (pix_last),
        .pix_en    (pix_en),
        .pix_data  (pix_data)
    );

endmodule

// File: tb/tb_bmp_stream_unpacker.sv
// Scoreboard bench: two instances (RGB565 and RGB888) share one byte stream.
// Expected RGB triples are queued as pixel bytes are issued; a monitor pops
// and compares on every pixel strobe.
module tb_bmp_stream_unpacker;

    localparam int MAX_DIM = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] expect_width;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        write_req_ack;

    logic        wr0, pe0, busy0, done0, err0;
    logic [15:0] pd0;
    logic [1:0]  ec0;
    logic        wr1, pe1, busy1, done1, err1;
    logic [23:0] pd1;
    logic [1:0]  ec1;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;
    logic [23:0] exp_q[$];

    bmp_stream_unpacker #(.OUT_FMT(0), .OUT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .expect_width(expect_width),
        .byte_data(byte_data), .byte_valid(byte_valid), .write_req(wr0),
        .write_req_ack(write_req_ack), .pix_en(pe0), .pix_data(pd0), .busy(busy0),
        .done(done0), .err(err0), .err_code(ec0)
    );

    bmp_stream_unpacker #(.OUT_FMT(1), .OUT_W(24)) dut1 (
        .clk(clk), .rst(rst), .start(start), .expect_width(expect_width),
        .byte_data(byte_data), .byte_valid(byte_valid), .write_req(wr1),
        .write_req_ack(write_req_ack), .pix_en(pe1), .pix_data(pd1), .busy(busy1),
        .done(done1), .err(err1), .err_code(ec1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] rgb);
        int r, g, b;
        r = int'(rgb[23:16]);
        g = int'(rgb[15:8]);
        b = int'(rgb[7:0]);
        return 16'(((r / 8) * 2048) + ((g / 4) * 32) + (b / 8));
    endfunction

    // Header acceptance rules, first failing rule wins
    function automatic int model_err(input int sig0, input int sig1, input int bpp,
                                     input longint w, input int h, input int expw);
        longint habs;
        habs = (h < 0) ? -longint'(h) : longint'(h);
        if (sig0 != 'h42 || sig1 != 'h4D) return 1;
        if (bpp != 24 && bpp != 32) return 2;
        if (w < 1 || w > MAX_DIM || (expw != 0 && w != expw)) return 3;
        if (habs < 1 || habs > MAX_DIM) return 3;
        return 0;
    endfunction

    // Monitor: every pixel strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (pe0 || pe1) begin
                logic [23:0] e;
                check("pix_en_agree", {31'd0, pe0}, {31'd0, pe1});
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix565", {16'd0, pd0}, {16'd0, to565(e)});
                    check("pix888", {8'd0, pd1}, {8'd0, e});
                end
            end
            if (done0 || done1) begin
                done_seen++;
                check("done_agree", {31'd0, done0}, {31'd0, done1});
                check("busy_at_done", {31'd0, busy0}, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_start(input int ack_delay);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("write_req_on_start", {31'd0, wr0}, 32'd1);
        check("busy_on_start", {31'd0, busy0}, 32'd1);
        check("err_cleared", {29'd0, err1, ec0}, 32'd0);
        repeat (ack_delay) @(negedge clk);
        write_req_ack = 1'b1;
        @(negedge clk);
        write_req_ack = 1'b0;
        check("write_req_after_ack", {31'd0, wr0}, 32'd0);
    endtask

    task automatic frame_body(input logic [7:0] sig0, input logic [7:0] sig1,
                              input int off, input int w, input int h,
                              input int bpp, input int expw, input int pat);
        logic [7:0]  hdr [30];
        logic [7:0]  pb [4];
        logic [31:0] offv, wv, hv, bv;
        int e, dc0, habs, bpb, pad;
        offv = 32'(off); wv = 32'(w); hv = 32'(h); bv = 32'(bpp);
        expect_width = 16'(expw);
        for (int i = 0; i < 30; i++) hdr[i] = 8'($urandom);
        hdr[0] = sig0;
        hdr[1] = sig1;
        for (int k = 0; k < 4; k++) begin
            hdr[10 + k] = offv[8*k +: 8];
            hdr[18 + k] = wv[8*k +: 8];
            hdr[22 + k] = hv[8*k +: 8];
        end
        hdr[28] = bv[7:0];
        hdr[29] = bv[15:8];
        e   = model_err(int'(sig0), int'(sig1), bpp, longint'(w), h, expw);
        dc0 = done_seen;
        for (int i = 0; i < 30; i++) send_byte(hdr[i]);
        if (e != 0) begin
            repeat (6) send_byte(8'($urandom));
            repeat (2) @(negedge clk);
            check("err_flag", {30'd0, err0, err1}, 32'd3);
            check("err_code565", {30'd0, ec0}, 32'(e));
            check("err_code888", {30'd0, ec1}, 32'(e));
            check("busy_after_err", {30'd0, busy0, wr0}, 32'd0);
            check("done_on_error", 32'(done_seen), 32'(dc0));
        end else begin
            for (int i = 30; i < off; i++) send_byte(8'($urandom));
            habs = (h < 0) ? -h : h;
            bpb  = bpp / 8;
            pad  = (4 - ((w * bpb) % 4)) % 4;
            for (int r = 0; r < habs; r++) begin
                for (int c = 0; c < w; c++) begin
                    if (pat == 1) begin
                        pb[0] = (c % 2 == 0) ? 8'hFF : 8'h00;
                        pb[1] = (c % 2 == 0) ? 8'h00 : 8'hFF;
                        pb[2] = 8'h00;
                        pb[3] = 8'h00;
                    end else if (pat == 2) begin
                        pb[0] = 8'h10; pb[1] = 8'h20; pb[2] = 8'h30; pb[3] = 8'h40;
                    end else begin
                        for (int j = 0; j < 4; j++) pb[j] = 8'($urandom);
                    end
                    exp_q.push_back({pb[2], pb[1], pb[0]});
                    for (int j = 0; j < bpb; j++) send_byte(pb[j]);
                end
                for (int p = 0; p < pad; p++) send_byte(8'h00);
            end
            repeat (3) @(negedge clk);
            check("pixels_missing", 32'(exp_q.size()), 32'd0);
            check("done_count", 32'(done_seen), 32'(dc0 + 1));
            check("idle_after_done", {29'd0, busy0, err0, wr0}, 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input logic [7:0] sig0, input logic [7:0] sig1,
                             input int off, input int w, input int h,
                             input int bpp, input int expw, input int pat);
        expect_width = 16'(expw);
        do_start(int'($urandom_range(0, 3)));
        frame_body(sig0, sig1, off, w, h, bpp, expw, pat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl0"}, {27'd0, wr0, pe0, busy0, done0, err0}, 32'd0);
        check({tag, "_ctl1"}, {27'd0, wr1, pe1, busy1, done1, err1}, 32'd0);
        check({tag, "_data"}, {16'd0, pd0}, 32'd0);
        check({tag, "_data888"}, {8'd0, pd1}, 32'd0);
        check({tag, "_code"}, {28'd0, ec0, ec1}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; expect_width = 16'd0;
        byte_data = 8'd0; byte_valid = 1'b0; write_req_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed frames
        run_frame(8'h42, 8'h4D, 54, 2, 2, 24, 0, 1);
        run_frame(8'h42, 8'h4D, 54, 3, 1, 32, 0, 2);
        run_frame(8'h42, 8'h4E, 54, 2, 2, 24, 0, 0);
        run_frame(8'h42, 8'h4D, 54, 320, 2, 24, 640, 0);
        run_frame(8'h42, 8'h4D, 54, 2, 2, 16, 0, 0);
        run_frame(8'h42, 8'h4D, 20, 3, -2, 24, 3, 0);
        run_frame(8'h42, 8'h4D, 30, 1, 3, 24, 0, 0);
        run_frame(8'h42, 8'h4D, 31, 5, 2, 24, 0, 0);
        run_frame(8'h42, 8'h4D, 54, 2, 0, 24, 0, 0);

        // Reset in the middle of the pixel array
        expect_width = 16'd0;
        do_start(1);
        send_byte(8'h42); send_byte(8'h4D);
        for (int i = 2; i < 30; i++) begin
            if (i == 10) send_byte(8'd54);
            else if (i == 18 || i == 22) send_byte(8'd2);
            else if (i == 28) send_byte(8'd24);
            else send_byte(8'h00);
        end
        for (int i = 30; i < 54; i++) send_byte(8'($urandom));
        exp_q.push_back(24'h0000FF);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        check("pix_before_reset", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check_all_zero("mid_pix_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) send_byte(8'($urandom));
        check("write_req_held", {30'd0, wr0, busy0}, 32'd3);
        write_req_ack = 1'b1;
        @(negedge clk);
        write_req_ack = 1'b0;
        frame_body(8'h42, 8'h4D, 40, 3, 2, 24, 0, 0);

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            int w, h, bpp, off, expw, kind;
            logic [7:0] s1;
            kind = int'($urandom_range(0, 9));
            w    = int'($urandom_range(1, 6));
            h    = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) h = -h;
            bpp  = ($urandom_range(0, 1) == 1) ? 32 : 24;
            off  = int'($urandom_range(20, 64));
            expw = ($urandom_range(0, 2) == 0) ? w : 0;
            s1   = 8'h4D;
            case (kind)
                6: w = 0;
                7: s1 = 8'h00;
                8: bpp = ($urandom_range(0, 1) == 1) ? 16 : 8;
                9: expw = w + 1;
                default: ;
            endcase
            run_frame(8'h42, s1, off, w, h, bpp, expw, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
